// File: rtl/mprj_uart_pkg.sv
// Shared types and helpers for the mprj_uart_tx serial transmitter.
package mprj_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mprj_uart_fifo.sv
// Synchronous byte FIFO with power-of-two depth; the pointer MSB separates full from empty.
module mprj_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("mprj_uart_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mprj_uart_tx.sv
// 8-bit UART transmitter fed from a byte FIFO; frames are 8N1, or 8E1 when
// MPRJ_UART_TX_PARITY_EN is defined.
module mprj_uart_tx
  import mprj_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("mprj_uart_tx: baud divisor must be at least 2");
  end

  uart_state_t   state;
  uart_state_t   next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          rst_done;
  logic          bit_end;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
`ifdef MPRJ_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // rst_done holds tx_ready low until the first edge after reset release.
  assign tx_ready = resetb && rst_done && !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign bit_end  = (baud_cnt == CNT_LAST);

  mprj_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (tx_valid && tx_ready),
    .pop    (fifo_pop),
    .din    (tx_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == BIT_LAST) begin
`ifdef MPRJ_UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef MPRJ_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) next_state = STOP;
      end
`endif
      // Back-to-back frames: the next byte goes straight into START.
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      rst_done <= 1'b0;
`ifdef MPRJ_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      rst_done <= 1'b1;
      state    <= next_state;
      if (fifo_pop) begin
        shift    <= fifo_dout;
        bit_idx  <= '0;
        baud_cnt <= '0;
`ifdef MPRJ_UART_TX_PARITY_EN
        parity_q <= ^fifo_dout;
`endif
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + CNT_ONE;
        end
      end
      // Line level follows the state one cycle later, so every bit still lasts DIV cycles.
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift[0];
`ifdef MPRJ_UART_TX_PARITY_EN
        PARITY:  tx_q <= parity_q;
`endif
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule
